// File: rtl/uart_operand_link.sv
// uart_operand_link: 8N1 UART link that receives an operand pair (a, b) and transmits a result byte.
module uart_operand_link #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       dout,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       ready,
  input  logic [7:0] result,
  input  logic       tx_en,
  output logic       tx_busy,
  output logic       rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
  localparam logic [1:0] T_IDLE = 2'd0, T_START = 2'd1, T_DATA = 2'd2, T_STOP = 2'd3;
  logic          din_m, din_s, ptr, tx_en_d, tx_edge;
  logic [1:0]    rx_state, tx_state;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0]    rx_bit, tx_bit;
  logic [7:0]    rx_sh, tx_sh;
  assign tx_edge = tx_en & ~tx_en_d;
  // Accept is assigned after the tx_en acknowledge so it wins when both land together.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {din_m, din_s} <= 2'b11;
      rx_state       <= R_IDLE;
      rx_cnt         <= '0;
      rx_bit         <= '0;
      rx_sh          <= '0;
      a              <= '0;
      b              <= '0;
      ready          <= 1'b0;
      ptr            <= 1'b0;
      rx_frame_err   <= 1'b0;
    end else begin
      din_m        <= din;
      din_s        <= din_m;
      rx_frame_err <= 1'b0;
      rx_cnt       <= rx_cnt + 1'b1;
      if (tx_edge) ready <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (!din_s) rx_state <= R_START;
        end
        R_START: if (rx_cnt == HALF_END) begin
          rx_cnt   <= '0;
          rx_state <= din_s ? R_IDLE : R_DATA;
        end
        R_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          rx_sh  <= {din_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= R_STOP;
        end
        default: if (rx_cnt == BIT_END) begin
          rx_state <= R_IDLE;
          if (!din_s) rx_frame_err <= 1'b1;
          else if (ptr) begin
            b     <= rx_sh;
            ready <= 1'b1;
            ptr   <= 1'b0;
          end else begin
            a     <= rx_sh;
            ready <= 1'b0;
            ptr   <= 1'b1;
          end
        end
      endcase
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_en_d  <= 1'b0;
      tx_busy  <= 1'b0;
      dout     <= 1'b1;
    end else begin
      tx_en_d <= tx_en;
      tx_cnt  <= tx_cnt + 1'b1;
      case (tx_state)
        T_IDLE: begin
          tx_cnt <= '0;
          if (tx_edge) begin
            tx_sh    <= result;
            tx_busy  <= 1'b1;
            dout     <= 1'b0;
            tx_state <= T_START;
          end
        end
        T_START: if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          dout     <= tx_sh[0];
          tx_sh    <= tx_sh >> 1;
          tx_state <= T_DATA;
        end
        T_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          tx_bit <= tx_bit + 1'b1;
          dout   <= (tx_bit == 3'd7) ? 1'b1 : tx_sh[0];
          tx_sh  <= tx_sh >> 1;
          if (tx_bit == 3'd7) tx_state <= T_STOP;
        end
        default: if (tx_cnt == BIT_END) begin
          tx_busy  <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_operand_link.sv
// tb_uart_operand_link: random-stimulus bench comparing the link against a frame-level reference model.
module tb_uart_operand_link;
  localparam int CPB = 16;
  logic clk = 0, reset = 1, din = 1, tx_en = 0;
  logic [7:0] result = 0;
  logic dout, ready, tx_busy, rx_frame_err;
  logic [7:0] a, b;
  int vectors = 0, miscompares = 0, frames = 0, errs = 0;
  logic busy_q = 0;
  logic [7:0] m_a = 0, m_b = 0;
  logic m_ready = 0, m_ptr = 0;
  uart_operand_link #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .a(a), .b(b), .ready(ready),
    .result(result), .tx_en(tx_en), .tx_busy(tx_busy), .rx_frame_err(rx_frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (tx_busy && !busy_q) frames++;
    busy_q = tx_busy;
    if (rx_frame_err) errs++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_regs(input string tag);
    check({tag, "_a"}, a, m_a);
    check({tag, "_b"}, b, m_b);
    check({tag, "_ready"}, ready, m_ready);
  endtask
  function automatic void model_accept(input logic [7:0] v);
    if (!m_ptr) begin
      m_a = v;
      m_ready = 0;
    end else begin
      m_b = v;
      m_ready = 1;
    end
    m_ptr = ~m_ptr;
  endfunction
  task automatic send_byte(input logic [7:0] v, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      din = f[i];
      repeat (CPB) @(negedge clk);
    end
    din = 1;
    repeat (20) @(negedge clk);
    if (stop_ok) model_accept(v);
  endtask
  task automatic tx_frame(input logic [7:0] v, input int toggle_at);
    logic [9:0] f;
    logic [7:0] got;
    int bad, busy, f0;
    f = {1'b1, v, 1'b0};
    bad = 0;
    busy = 0;
    got = 0;
    f0 = frames;
    result = v;
    @(negedge clk);
    tx_en = 1;
    m_ready = 0;
    for (int t = 0; t < 170; t++) begin
      @(negedge clk);
      if (t == 0) begin
        check("tx_ack_ready", ready, 0);
        result = ~v;
      end
      if (t < 10 * CPB) begin
        if (dout !== f[t / CPB]) bad++;
        if (t % CPB == CPB / 2 && t / CPB >= 1 && t / CPB <= 8) got[t / CPB - 1] = dout;
      end else if (dout !== 1'b1) bad++;
      if (tx_busy) busy++;
      if (t == toggle_at) tx_en = 0;
      if (t == toggle_at + 2) begin
        tx_en = 1;
        m_ready = 0;
      end
    end
    check("tx_byte", got, v);
    check("tx_bad_cycles", bad, 0);
    check("tx_busy_len", busy, 10 * CPB);
    check("tx_frames", frames - f0, 1);
  endtask
  initial begin
    int bad, e0, f0;
    logic [7:0] x, y, t;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_err", rx_frame_err, 0);
    check_regs("rst");
    reset = 0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dout !== 1 || tx_busy !== 0 || ready !== 0 || a !== 0 || b !== 0 || rx_frame_err !== 0) bad++;
    end
    check("idle_hold", bad, 0);
    send_byte(8'h3C, 1);
    check_regs("pair1");
    send_byte(8'hA5, 1);
    check_regs("pair2");
    tx_frame(8'h5A, -10);
    tx_en = 0;
    check_regs("after_tx");
    repeat (5) @(negedge clk);
    tx_frame(8'hC3, 40);
    f0 = frames;
    repeat (200) @(negedge clk);
    check("toggle_one_frame", frames - f0, 0);
    tx_en = 0;
    repeat (5) @(negedge clk);
    tx_frame(8'h81, -10);
    f0 = frames;
    repeat (300) @(negedge clk);
    check("held_one_frame", frames - f0, 0);
    tx_en = 0;
    repeat (5) @(negedge clk);
    e0 = errs;
    din = 0;
    repeat (5) @(negedge clk);
    din = 1;
    repeat (40) @(negedge clk);
    check("glitch_err", errs - e0, 0);
    check_regs("glitch");
    send_byte(8'h11, 1);
    check_regs("pre_err");
    e0 = errs;
    send_byte(8'h77, 0);
    check("frame_err_pulses", errs - e0, 1);
    check_regs("frame_err");
    send_byte(8'h22, 1);
    check_regs("post_err");
    result = 8'hF0;
    tx_en = 1;
    din = 0;
    repeat (80) @(negedge clk);
    reset = 1;
    #1;
    check("midrst_dout", dout, 1);
    check("midrst_busy", tx_busy, 0);
    m_a = 0;
    m_b = 0;
    m_ready = 0;
    m_ptr = 0;
    check_regs("midrst");
    @(negedge clk);
    tx_en = 0;
    din = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dout !== 1 || tx_busy !== 0) bad++;
    end
    check("no_resume", bad, 0);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    check_regs("fresh_pair");
    for (int k = 0; k < 4; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      t = 8'($urandom);
      fork
        send_byte(x, 1);
        tx_frame(t, -10);
      join
      tx_en = 0;
      check_regs("dup_a");
      send_byte(y, 1);
      check_regs("dup_b");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
